sequenciador_medidas_n: RTL
===========================

// Module: sequenciador_medidas_n
// PURPOSE
//  Parametrised successor of the single-sensor TUSCA measurement path. Drives NUM_SENSORES
//  DHT11 interfaces round-robin through their start/pronto/erro handshakes, with bounded retries.
//  Latches the last good reading per channel and aggregates worst-case temperatura/umidade for the
//  comparators, then waits PERIODO_DELAY before the next sweep. Sits between dht11 instances and comparador_*.
// PARAMETERS
//  NUM_SENSORES    4            channels swept per cycle (1..16)
//  LARGURA         16           width of each temperatura/umidade word
//  PERIODO_DELAY   100_000_000  idle cycles between sweeps (2 s @ 50 MHz)
//  MAX_TENTATIVAS  3            attempts per channel before it is marked falho (>=1)
//  TIMEOUT         50_000_000   watchdog cycles per attempt (only with TUSCA_TIMEOUT_EN)
// PORTS
//  clock            in   1                 system clock
//  reset            in   1                 synchronous, active-high
//  habilita         in   1                 1 = sweep continuously; 0 = stop after current sweep
//  medir_agora      in   1                 pulse: skip remaining delay, start sweep next cycle
//  start_sensor     out  N                 one-cycle start pulse to channel i
//  pronto_sensor    in   N                 channel i finished OK (one-cycle pulse)
//  erro_sensor      in   N                 channel i finished with error (one-cycle pulse)
//  temperatura_in   in   N*LARGURA         packed; channel i at [i*LARGURA +: LARGURA]
//  umidade_in       in   N*LARGURA         packed, same layout
//  temperatura_max  out  LARGURA           max temperatura over valid channels
//  umidade_max      out  LARGURA           max umidade over valid channels
//  valido           out  N                 bit i = channel i holds a reading from the last sweep
//  falha            out  N                 bit i = channel i exhausted MAX_TENTATIVAS last sweep
//  nova_medida      out  1                 one-cycle pulse when aggregates update
//  canal_atual      out  $clog2(N)+1       channel being serviced
//  db_estado        out  3                 FSM state encoding below
// BEHAVIOUR
//  Reset (sync, highest priority, any state): FSM->OCIOSO; all outputs 0; counters 0; stored readings 0.
//  States: OCIOSO=0 DISPARA=1 AGUARDA=2 REGISTRA=3 PROXIMO=4 AGREGA=5 ESPERA=6.
//  OCIOSO: habilita|medir_agora -> DISPARA, canal_atual=0, tentativa=0, valido/falha cleared.
//  DISPARA: start_sensor[canal_atual]=1 for exactly 1 cycle -> AGUARDA. Never two start bits high.
//  AGUARDA: only pronto/erro of canal_atual honoured; other channels' pulses ignored.
//   pronto (has priority if pronto&erro same cycle) -> REGISTRA.
//   erro: tentativa+1 < MAX_TENTATIVAS -> tentativa++, DISPARA; else falha[i]=1, PROXIMO.
//  REGISTRA: latch channel slice of temperatura_in/umidade_in, valido[i]=1 -> PROXIMO (1 cycle).
//  PROXIMO: tentativa=0; canal_atual==N-1 -> AGREGA; else canal_atual++ -> DISPARA.
//  AGREGA: compute max over channels with valido=1 (unsigned compare); update outputs,
//   nova_medida=1 for 1 cycle -> ESPERA. No valid channel: aggregates hold previous value,
//   nova_medida still pulses. Max may be a combinational tree or iterative; output change visible
//   at the nova_medida cycle.
//  ESPERA: delay counter 0..PERIODO_DELAY-1; at terminal count or medir_agora:
//   habilita=1 -> DISPARA (new sweep, canal 0, masks cleared); habilita=0 -> OCIOSO.
//  medir_agora in any state other than OCIOSO/ESPERA ignored (no sweep restart).
//  Outputs stable between nova_medida pulses; valido/falha reflect the in-progress sweep.
//  Minimum sweep latency with immediate pronto: N*(DISPARA+AGUARDA+REGISTRA+PROXIMO)+1 cycles.
// CONFIGURATION
//  TUSCA_TIMEOUT_EN defined: per-attempt watchdog in AGUARDA; counter clears on DISPARA.
//   Reaching TIMEOUT cycles without pronto/erro is treated exactly as erro (retry or falha).
//  Not defined: AGUARDA waits indefinitely; TIMEOUT unused; no watchdog logic synthesised.
// TESTING
//  T1 N=4, all sensors pronto after 10 cycles, temps 20,35,27,31 -> temperatura_max=35,
//   valido=4'hF, falha=0, one nova_medida pulse, start pulses in order 0..3.
//  T2 ch2 erro twice then pronto (MAX_TENTATIVAS=3) -> 3 start pulses on ch2, valido[2]=1, falha=0.
//  T3 ch1 erro 3 times -> falha=4'b0010, valido=4'b1101, max excludes ch1 (ch1 temp 99 ignored).
//  T4 pronto_sensor[3] pulsed while servicing ch0 -> ignored; reset asserted in AGUARDA ->
//   next cycle db_estado=0, all outputs 0.
//  T5 PERIODO_DELAY=20, medir_agora in ESPERA at cycle 5 -> DISPARA next cycle; habilita=0 -> OCIOSO after sweep.
//  T6 TUSCA_TIMEOUT_EN, TIMEOUT=100, ch0 silent -> retries at +101 cycles, falha[0]=1 after 3;
//   without macro -> stays in AGUARDA.

Source files
------------

// File: rtl/sequenciador_medidas_n.sv
// Round-robin measurement sequencer for NUM_SENSORES DHT11 channels with retries and max aggregation.
// Define TUSCA_TIMEOUT_EN to add a per-attempt watchdog that treats TIMEOUT silent cycles as erro.
module sequenciador_medidas_n #(
    parameter int NUM_SENSORES   = 4,
    parameter int LARGURA        = 16,
    parameter int PERIODO_DELAY  = 100_000_000,
    parameter int MAX_TENTATIVAS = 3,
    parameter int TIMEOUT        = 50_000_000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              habilita,
    input  logic                              medir_agora,
    output logic [NUM_SENSORES-1:0]           start_sensor,
    input  logic [NUM_SENSORES-1:0]           pronto_sensor,
    input  logic [NUM_SENSORES-1:0]           erro_sensor,
    input  logic [NUM_SENSORES*LARGURA-1:0]   temperatura_in,
    input  logic [NUM_SENSORES*LARGURA-1:0]   umidade_in,
    output logic [LARGURA-1:0]                temperatura_max,
    output logic [LARGURA-1:0]                umidade_max,
    output logic [NUM_SENSORES-1:0]           valido,
    output logic [NUM_SENSORES-1:0]           falha,
    output logic                              nova_medida,
    output logic [$clog2(NUM_SENSORES):0]     canal_atual,
    output logic [2:0]                        db_estado
);

    localparam int CW = $clog2(NUM_SENSORES) + 1;
    localparam int IW = (NUM_SENSORES > 1) ? $clog2(NUM_SENSORES) : 1;
    localparam int TW = $clog2(MAX_TENTATIVAS + 1);
    localparam int DW = $clog2(PERIODO_DELAY + 1);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        DISPARA  = 3'd1,
        AGUARDA  = 3'd2,
        REGISTRA = 3'd3,
        PROXIMO  = 3'd4,
        AGREGA   = 3'd5,
        ESPERA   = 3'd6
    } estado_t;

    estado_t estado;
    estado_t prox;

    logic [IW-1:0]      idx;
    logic [TW-1:0]      tentativa;
    logic [DW-1:0]      cont_delay;
    logic [LARGURA-1:0] temp_reg [NUM_SENSORES];
    logic [LARGURA-1:0] umid_reg [NUM_SENSORES];

    logic               pronto_c;
    logic               erro_c;
    logic               esgotou;
    logic               ultimo;
    logic               fim_delay;
    logic               nova_varredura;
    logic               algum_valido;
    logic [LARGURA-1:0] t_max;
    logic [LARGURA-1:0] u_max;

    assign idx       = canal_atual[IW-1:0];
    assign db_estado = estado;

`ifdef TUSCA_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] cont_wd;

    // Counts cycles spent in the current attempt; any other state restarts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_wd <= '0;
        end else if (estado == AGUARDA) begin
            cont_wd <= cont_wd + 1'b1;
        end else begin
            cont_wd <= '0;
        end
    end

    assign erro_c = erro_sensor[idx] | (cont_wd == WW'(TIMEOUT - 1));
`else
    assign erro_c = erro_sensor[idx];
`endif

    assign pronto_c  = pronto_sensor[idx];
    assign esgotou   = (int'(tentativa) + 1) >= MAX_TENTATIVAS;
    assign ultimo    = (canal_atual == CW'(NUM_SENSORES - 1));
    assign fim_delay = (cont_delay == DW'(PERIODO_DELAY - 1));
    assign nova_varredura =
        (estado == OCIOSO || estado == ESPERA) && prox == DISPARA;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox         = estado;
        start_sensor = '0;
        nova_medida  = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (habilita || medir_agora) begin
                    prox = DISPARA;
                end
            end
            DISPARA: begin
                start_sensor[idx] = 1'b1;
                prox              = AGUARDA;
            end
            AGUARDA: begin
                if (pronto_c) begin
                    prox = REGISTRA;
                end else if (erro_c) begin
                    prox = esgotou ? PROXIMO : DISPARA;
                end
            end
            REGISTRA: prox = PROXIMO;
            PROXIMO:  prox = ultimo ? AGREGA : DISPARA;
            AGREGA: begin
                nova_medida = 1'b1;
                prox        = ESPERA;
            end
            ESPERA: begin
                if (fim_delay || medir_agora) begin
                    prox = habilita ? DISPARA : OCIOSO;
                end
            end
            default: prox = OCIOSO;
        endcase
    end

    // Unsigned max over the channels that produced a reading this sweep.
    always_comb begin
        t_max        = '0;
        u_max        = '0;
        algum_valido = 1'b0;
        for (int i = 0; i < NUM_SENSORES; i++) begin
            if (valido[i]) begin
                algum_valido = 1'b1;
                if (temp_reg[i] > t_max) begin
                    t_max = temp_reg[i];
                end
                if (umid_reg[i] > u_max) begin
                    u_max = umid_reg[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            canal_atual     <= '0;
            tentativa       <= '0;
            valido          <= '0;
            falha           <= '0;
            temperatura_max <= '0;
            umidade_max     <= '0;
            for (int i = 0; i < NUM_SENSORES; i++) begin
                temp_reg[i] <= '0;
                umid_reg[i] <= '0;
            end
        end else begin
            if (nova_varredura) begin
                canal_atual <= '0;
                tentativa   <= '0;
                valido      <= '0;
                falha       <= '0;
            end
            if (estado == AGUARDA && !pronto_c && erro_c) begin
                if (esgotou) begin
                    falha[idx] <= 1'b1;
                end else begin
                    tentativa <= tentativa + 1'b1;
                end
            end
            if (estado == REGISTRA) begin
                temp_reg[idx] <= temperatura_in[int'(idx)*LARGURA +: LARGURA];
                umid_reg[idx] <= umidade_in[int'(idx)*LARGURA +: LARGURA];
                valido[idx]   <= 1'b1;
            end
            // Aggregates load on entry to AGREGA so they change with nova_medida.
            if (estado == PROXIMO) begin
                tentativa <= '0;
                if (!ultimo) begin
                    canal_atual <= canal_atual + 1'b1;
                end else if (algum_valido) begin
                    temperatura_max <= t_max;
                    umidade_max     <= u_max;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_delay <= '0;
        end else if (estado == ESPERA) begin
            cont_delay <= cont_delay + 1'b1;
        end else begin
            cont_delay <= '0;
        end
    end

endmodule
